// File: rtl/systolic_compute_sequencer.sv
// rtl/systolic_compute_sequencer.sv - tile-grid sequencer for a MUL_SIZE x MUL_SIZE systolic array
module systolic_compute_sequencer #(
  parameter int MUL_SIZE = 32,
  parameter int DIM_W    = 9,
  parameter int TILE_W   = 4,
  parameter int ADDR_W   = 12,
  parameter int ACT_LAT  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [DIM_W-1:0]         n_rows_m1_i,
  input  logic [TILE_W-1:0]        k_tiles_m1_i,
  input  logic [TILE_W-1:0]        n_tiles_m1_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic                     weights_rdy_i,
  input  logic                     stall_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     act_rd_o,
  output logic [ADDR_W-1:0]        act_addr_o,
  output logic                     mac_en_o,
  output logic                     acc_first_o,
  output logic [MUL_SIZE*MUL_SIZE-1:0] weight_sel_o,
  output logic                     weight_consume_o,
  output logic [TILE_W-1:0]        tile_x_o,
  output logic [TILE_W-1:0]        tile_y_o
);

  localparam int NPE       = MUL_SIZE * MUL_SIZE;
  localparam int SWAP_LAST = 2 * MUL_SIZE - 2;
  localparam int KW        = $clog2(2 * MUL_SIZE);
  localparam int OW        = TILE_W + DIM_W + 1;

  typedef enum logic [2:0] {IDLE, WAIT_W, SWAP, COMPUTE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [DIM_W-1:0]    rows_q;
  logic [DIM_W-1:0]    row_q;
  logic [TILE_W-1:0]   kt_q;
  logic [TILE_W-1:0]   nt_q;
  logic [TILE_W-1:0]   x_q;
  logic [TILE_W-1:0]   y_q;
  logic [ADDR_W-1:0]   base_q;
  logic [KW-1:0]       k_q;
  logic [NPE-1:0]      sel_q;
  logic [ACT_LAT-1:0]  rd_dl_q;
  logic [ACT_LAT-1:0]  af_dl_q;

  logic [ACT_LAT-1:0]  rd_dl_d;
  logic [ACT_LAT-1:0]  af_dl_d;
  logic [NPE-1:0]      diag_mask;
  logic [OW-1:0]       offset;
  logic [ADDR_W-1:0]   addr_c;
  logic                rd_push;
  logic                drain_empty;
  logic                last_tile;

  // Anti-diagonal r+c==k of the PE grid: the PEs whose select flips this SWAP cycle.
  always_comb begin
    diag_mask = '0;
    for (int r = 0; r < MUL_SIZE; r++) begin
      for (int c = 0; c < MUL_SIZE; c++) begin
        if (r + c == int'(k_q)) diag_mask[r*MUL_SIZE+c] = 1'b1;
      end
    end
  end

  // Activation address wraps modulo 2^ADDR_W; offset is wide enough to never overflow itself.
  assign offset      = OW'(y_q) * (OW'(rows_q) + OW'(1)) + OW'(row_q);
  assign addr_c      = base_q + ADDR_W'(offset);
  assign rd_push     = (state_q == COMPUTE);
  assign rd_dl_d     = (rd_dl_q << 1) | ACT_LAT'(rd_push);
  assign af_dl_d     = (af_dl_q << 1) | ACT_LAT'(rd_push && (y_q == '0));
  assign drain_empty = (rd_dl_q == '0);
  assign last_tile   = (x_q == nt_q) && (y_q == kt_q);

  // Outputs decode registered state; stall masks every strobe in the same cycle.
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE) && !stall_i;
  assign act_rd_o         = rd_push && !stall_i;
  assign act_addr_o       = act_rd_o ? addr_c : '0;
  assign mac_en_o         = rd_dl_q[ACT_LAT-1] && !stall_i;
  assign acc_first_o      = af_dl_q[ACT_LAT-1] && mac_en_o;
  assign weight_consume_o = (state_q == DRAIN) && drain_empty && !stall_i;
  assign weight_sel_o     = sel_q;
  assign tile_x_o         = x_q;
  assign tile_y_o         = y_q;

  // Command FSM: everything except IDLE freezes while stall_i is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rows_q  <= '0;
      row_q   <= '0;
      kt_q    <= '0;
      nt_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      k_q     <= '0;
      sel_q   <= '0;
      rd_dl_q <= '0;
      af_dl_q <= '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        rows_q  <= n_rows_m1_i;
        kt_q    <= k_tiles_m1_i;
        nt_q    <= n_tiles_m1_i;
        base_q  <= base_addr_i;
        x_q     <= '0;
        y_q     <= '0;
        state_q <= WAIT_W;
      end
    end else if (!stall_i) begin
      rd_dl_q <= rd_dl_d;
      af_dl_q <= af_dl_d;
      case (state_q)
        WAIT_W: begin
          if (weights_rdy_i) begin
            k_q     <= '0;
            state_q <= SWAP;
          end
        end
        SWAP: begin
          sel_q <= sel_q ^ diag_mask;
          if (k_q == KW'(SWAP_LAST)) begin
            row_q   <= '0;
            state_q <= COMPUTE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        COMPUTE: begin
          if (row_q == rows_q) state_q <= DRAIN;
          else row_q <= row_q + 1'b1;
        end
        DRAIN: begin
          if (drain_empty) begin
            if (last_tile) begin
              state_q <= DONE;
            end else begin
              if (y_q == kt_q) begin
                y_q <= '0;
                x_q <= x_q + 1'b1;
              end else begin
                y_q <= y_q + 1'b1;
              end
              state_q <= WAIT_W;
            end
          end
        end
        DONE: begin
          x_q     <= '0;
          y_q     <= '0;
          rows_q  <= '0;
          kt_q    <= '0;
          nt_q    <= '0;
          base_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_compute_sequencer.sv
// tb/tb_systolic_compute_sequencer.sv - directed self-checking bench for systolic_compute_sequencer
module tb_systolic_compute_sequencer;

  localparam int M  = 4;
  localparam int DW = 9;
  localparam int TW = 4;
  localparam int AW = 12;
  localparam int AL = 2;

  logic          clk = 1'b0;
  logic          rst_i, start_i, weights_rdy_i, stall_i;
  logic [DW-1:0] n_rows_m1_i;
  logic [TW-1:0] k_tiles_m1_i, n_tiles_m1_i;
  logic [AW-1:0] base_addr_i;
  logic          busy_o, done_o, act_rd_o, mac_en_o, acc_first_o, weight_consume_o;
  logic [AW-1:0] act_addr_o;
  logic [M*M-1:0] weight_sel_o;
  logic [TW-1:0] tile_x_o, tile_y_o;

  systolic_compute_sequencer #(.MUL_SIZE(M), .DIM_W(DW), .TILE_W(TW), .ADDR_W(AW), .ACT_LAT(AL)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_rows_m1_i(n_rows_m1_i),
    .k_tiles_m1_i(k_tiles_m1_i), .n_tiles_m1_i(n_tiles_m1_i), .base_addr_i(base_addr_i),
    .weights_rdy_i(weights_rdy_i), .stall_i(stall_i), .busy_o(busy_o), .done_o(done_o),
    .act_rd_o(act_rd_o), .act_addr_o(act_addr_o), .mac_en_o(mac_en_o), .acc_first_o(acc_first_o),
    .weight_sel_o(weight_sel_o), .weight_consume_o(weight_consume_o),
    .tile_x_o(tile_x_o), .tile_y_o(tile_y_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int accept_cyc;

  logic [AW-1:0]  rd_addr[$];
  int             rd_cyc[$];
  int             mac_cyc[$];
  logic           mac_af[$];
  logic [TW-1:0]  cons_x[$], cons_y[$];
  int             cons_cyc[$];
  logic [M*M-1:0] sel_hist[$];
  int             sel_cyc[$];
  logic [M*M-1:0] last_sel;
  int n_done, done_cyc, n_busy, busy_first, busy_last, n_viol;

  logic [15:0] exp_sel [7] = '{16'h0001, 16'h0013, 16'h0137, 16'h137F, 16'h37FF, 16'h7FFF, 16'hFFFF};

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (act_rd_o) begin rd_addr.push_back(act_addr_o); rd_cyc.push_back(cyc); end
    if (mac_en_o) begin mac_cyc.push_back(cyc); mac_af.push_back(acc_first_o); end
    if (weight_consume_o) begin cons_x.push_back(tile_x_o); cons_y.push_back(tile_y_o); cons_cyc.push_back(cyc); end
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (busy_o) begin if (n_busy == 0) busy_first = cyc; n_busy++; busy_last = cyc; end
    if (weight_sel_o !== last_sel) begin sel_hist.push_back(weight_sel_o); sel_cyc.push_back(cyc); last_sel = weight_sel_o; end
    if (stall_i && (act_rd_o || mac_en_o || weight_consume_o || done_o)) n_viol++;
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    rd_addr.delete(); rd_cyc.delete(); mac_cyc.delete(); mac_af.delete();
    cons_x.delete(); cons_y.delete(); cons_cyc.delete(); sel_hist.delete(); sel_cyc.delete();
    last_sel = weight_sel_o;
    n_done = 0; done_cyc = 0; n_busy = 0; busy_first = 0; busy_last = 0; n_viol = 0;
  endtask

  task automatic issue(input int rows, input int kt, input int nt, input int base, input bit keep);
    n_rows_m1_i  = DW'(rows);
    k_tiles_m1_i = TW'(kt);
    n_tiles_m1_i = TW'(nt);
    base_addr_i  = AW'(base);
    start_i      = 1'b1;
    tick();
    accept_cyc = cyc;
    if (!keep) start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    start_i = 1'b1;
    do_reset();
    start_i = 1'b0;
    total++;
    if ({busy_o, done_o, act_rd_o, act_addr_o, mac_en_o, acc_first_o, weight_sel_o, weight_consume_o, tile_x_o, tile_y_o} !== '0)
      $display("FAIL reset_outputs: got busy=%b rd=%b addr=%h mac=%b sel=%h x=%h y=%h, want all 0",
               busy_o, act_rd_o, act_addr_o, mac_en_o, weight_sel_o, tile_x_o, tile_y_o);
    else passed++;
  endtask

  task automatic test_single_tile();
    bit ok;
    clear_log();
    weights_rdy_i = 1'b1;
    issue(3, 0, 0, 'h010, 1'b0);
    wait_done(200, ok);
    tick(); tick();
    total++; if (!ok) $display("FAIL t1_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 4) $display("FAIL t1_rd_count: got %0d want 4", rd_addr.size()); else passed++;
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      total++;
      if (rd_addr[i] !== AW'('h010 + i)) $display("FAIL t1_addr[%0d]: got %h want %h", i, rd_addr[i], AW'('h010 + i));
      else passed++;
    end
    total++; if (mac_cyc.size() != 4) $display("FAIL t1_mac_count: got %0d want 4", mac_cyc.size()); else passed++;
    for (int i = 0; i < 4 && i < mac_cyc.size() && i < rd_cyc.size(); i++) begin
      total++;
      if (mac_cyc[i] != rd_cyc[i] + 2) $display("FAIL t1_mac_lat[%0d]: got %0d want %0d", i, mac_cyc[i] - rd_cyc[i], 2);
      else passed++;
      total++;
      if (mac_af[i] !== 1'b1) $display("FAIL t1_acc_first[%0d]: got %b want 1", i, mac_af[i]); else passed++;
    end
    total++; if (sel_hist.size() != 7) $display("FAIL t1_sel_steps: got %0d want 7", sel_hist.size()); else passed++;
    for (int i = 0; i < 7 && i < sel_hist.size(); i++) begin
      total++;
      if (sel_hist[i] !== exp_sel[i]) $display("FAIL t1_sel[%0d]: got %h want %h", i, sel_hist[i], exp_sel[i]);
      else passed++;
    end
    if (sel_cyc.size() == 7) begin
      total++;
      if (sel_cyc[6] - sel_cyc[0] != 6) $display("FAIL t1_swap_span: got %0d want 6", sel_cyc[6] - sel_cyc[0]);
      else passed++;
    end
    total++; if (cons_cyc.size() != 1) $display("FAIL t1_consume_count: got %0d want 1", cons_cyc.size()); else passed++;
    if (cons_cyc.size() == 1 && mac_cyc.size() == 4) begin
      total++;
      if (cons_cyc[0] <= mac_cyc[3]) $display("FAIL t1_consume_order: got consume@%0d last mac@%0d want later", cons_cyc[0], mac_cyc[3]);
      else passed++;
    end
    total++; if (n_done != 1) $display("FAIL t1_done_count: got %0d want 1", n_done); else passed++;
    total++; if (busy_first != accept_cyc + 1) $display("FAIL t1_busy_rise: got %0d want %0d", busy_first, accept_cyc + 1); else passed++;
    total++; if (busy_last != done_cyc) $display("FAIL t1_busy_fall: got %0d want %0d", busy_last, done_cyc); else passed++;
    total++; if (n_busy != 16) $display("FAIL t1_busy_len: got %0d want 16", n_busy); else passed++;
  endtask

  task automatic test_tile_grid();
    bit ok;
    logic [AW-1:0] exp_a [6] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
    logic [TW-1:0] exp_x [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    logic [TW-1:0] exp_y [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic          exp_f [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clear_log();
    issue(1, 2, 1, 'hFFE, 1'b0);
    wait_done(500, ok);
    tick();
    total++; if (!ok) $display("FAIL t2_timeout: no done_o within budget"); else passed++;
    total++; if (cons_x.size() != 6) $display("FAIL t2_consume_count: got %0d want 6", cons_x.size()); else passed++;
    for (int i = 0; i < 6 && i < cons_x.size(); i++) begin
      total++;
      if (cons_x[i] !== exp_x[i] || cons_y[i] !== exp_y[i])
        $display("FAIL t2_tile[%0d]: got (%0d,%0d) want (%0d,%0d)", i, cons_x[i], cons_y[i], exp_x[i], exp_y[i]);
      else passed++;
    end
    total++; if (rd_addr.size() != 12) $display("FAIL t2_rd_count: got %0d want 12", rd_addr.size()); else passed++;
    for (int i = 0; i < 12 && i < rd_addr.size(); i++) begin
      total++;
      if (rd_addr[i] !== exp_a[i % 6]) $display("FAIL t2_addr[%0d]: got %h want %h", i, rd_addr[i], exp_a[i % 6]);
      else passed++;
    end
    total++; if (mac_af.size() != 12) $display("FAIL t2_mac_count: got %0d want 12", mac_af.size()); else passed++;
    for (int i = 0; i < 12 && i < mac_af.size(); i++) begin
      total++;
      if (mac_af[i] !== exp_f[i % 6]) $display("FAIL t2_acc_first[%0d]: got %b want %b", i, mac_af[i], exp_f[i % 6]);
      else passed++;
    end
    total++; if (n_done != 1) $display("FAIL t2_done_count: got %0d want 1", n_done); else passed++;
    total++; if (weight_sel_o !== 16'hFFFF) $display("FAIL t2_sel_final: got %h want FFFF", weight_sel_o); else passed++;
    total++; if (tile_x_o !== '0 || tile_y_o !== '0) $display("FAIL t2_tile_clear: got (%0d,%0d) want (0,0)", tile_x_o, tile_y_o); else passed++;
  endtask

  task automatic test_weights_wait();
    bit ok;
    bit held;
    int n_rd, n_mac, n_sel;
    do_reset();
    clear_log();
    weights_rdy_i = 1'b1;
    held = 1'b0;
    ok = 1'b0;
    issue(1, 1, 0, 'h040, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (n_done > 0) begin ok = 1'b1; break; end
      if (!held && cons_x.size() == 1) begin
        held = 1'b1;
        weights_rdy_i = 1'b0;
        n_rd = rd_addr.size(); n_mac = mac_cyc.size(); n_sel = sel_hist.size();
        for (int j = 0; j < 10; j++) tick();
        total++;
        if (rd_addr.size() != n_rd || mac_cyc.size() != n_mac)
          $display("FAIL t3_hold_activity: got rd=%0d mac=%0d want rd=%0d mac=%0d", rd_addr.size(), mac_cyc.size(), n_rd, n_mac);
        else passed++;
        total++;
        if (sel_hist.size() != n_sel) $display("FAIL t3_hold_sel: got %0d changes want %0d", sel_hist.size(), n_sel); else passed++;
        total++; if (busy_o !== 1'b1) $display("FAIL t3_hold_busy: got %b want 1", busy_o); else passed++;
        weights_rdy_i = 1'b1;
      end
    end
    total++; if (!ok) $display("FAIL t3_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 4) $display("FAIL t3_rd_count: got %0d want 4", rd_addr.size()); else passed++;
    total++; if (cons_x.size() != 2) $display("FAIL t3_consume_count: got %0d want 2", cons_x.size()); else passed++;
    total++; if (sel_hist.size() != 14) $display("FAIL t3_sel_steps: got %0d want 14", sel_hist.size()); else passed++;
    total++; if (weight_sel_o !== 16'h0000) $display("FAIL t3_sel_final: got %h want 0000", weight_sel_o); else passed++;
  endtask

  task automatic test_stall();
    bit ok, did_s, did_c;
    clear_log();
    did_s = 1'b0; did_c = 1'b0; ok = 1'b0;
    issue(3, 0, 0, 'h100, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (n_done > 0) begin ok = 1'b1; break; end
      if (!did_s && last_sel === 16'h0013) begin
        did_s = 1'b1; stall_i = 1'b1; tick(); tick(); stall_i = 1'b0;
      end
      if (!did_c && rd_addr.size() == 2) begin
        did_c = 1'b1; stall_i = 1'b1; tick(); tick(); tick(); stall_i = 1'b0;
      end
    end
    tick();
    total++; if (!ok) $display("FAIL t4_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 4) $display("FAIL t4_rd_count: got %0d want 4", rd_addr.size()); else passed++;
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      total++;
      if (rd_addr[i] !== AW'('h100 + i)) $display("FAIL t4_addr[%0d]: got %h want %h", i, rd_addr[i], AW'('h100 + i));
      else passed++;
    end
    total++; if (mac_cyc.size() != 4) $display("FAIL t4_mac_count: got %0d want 4", mac_cyc.size()); else passed++;
    total++; if (sel_hist.size() != 7) $display("FAIL t4_sel_steps: got %0d want 7", sel_hist.size()); else passed++;
    if (sel_cyc.size() == 7) begin
      total++;
      if (sel_cyc[6] - sel_cyc[0] != 8) $display("FAIL t4_swap_span: got %0d want 8", sel_cyc[6] - sel_cyc[0]);
      else passed++;
    end
    total++; if (n_viol != 0) $display("FAIL t4_stall_strobes: got %0d want 0", n_viol); else passed++;
    total++; if (n_busy != 21) $display("FAIL t4_busy_len: got %0d want 21", n_busy); else passed++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_log();
    ok = 1'b0;
    issue(3, 1, 0, 'h020, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rd_addr.size() == 6) begin ok = 1'b1; break; end
    end
    total++; if (!ok) $display("FAIL t5_reach_tile2: reads got %0d want 6", rd_addr.size()); else passed++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if ({busy_o, done_o, act_rd_o, act_addr_o, mac_en_o, acc_first_o, weight_sel_o, weight_consume_o, tile_x_o, tile_y_o} !== '0)
      $display("FAIL t5_reset_outputs: got busy=%b rd=%b addr=%h mac=%b sel=%h y=%h, want all 0",
               busy_o, act_rd_o, act_addr_o, mac_en_o, weight_sel_o, tile_y_o);
    else passed++;
    clear_log();
    issue(0, 0, 0, 'h055, 1'b0);
    wait_done(200, ok);
    total++; if (!ok) $display("FAIL t5_restart_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 1 || rd_addr[0] !== 12'h055) $display("FAIL t5_restart_addr: got n=%0d want one read at 055", rd_addr.size()); else passed++;
    total++; if (mac_cyc.size() != 1) $display("FAIL t5_restart_mac: got %0d want 1", mac_cyc.size()); else passed++;
  endtask

  task automatic test_start_handshake();
    bit ok;
    clear_log();
    ok = 1'b0;
    issue(0, 0, 0, 'h200, 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_done > 0) begin ok = 1'b1; start_i = 1'b0; break; end
    end
    start_i = 1'b0;
    tick(); tick(); tick();
    total++; if (!ok) $display("FAIL t6a_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 1 || rd_addr[0] !== 12'h200) $display("FAIL t6a_reads: got n=%0d want one read at 200", rd_addr.size()); else passed++;
    total++; if (n_busy != 13) $display("FAIL t6a_busy_len: got %0d want 13", n_busy); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL t6a_idle_after: got busy=%b want 0", busy_o); else passed++;

    clear_log();
    ok = 1'b0;
    issue(1, 0, 0, 'h300, 1'b0);
    base_addr_i = 12'h777;
    n_rows_m1_i = 9'd5;
    for (int i = 0; i < 200; i++) begin
      start_i = ~start_i;
      tick();
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    start_i = 1'b0;
    tick(); tick(); tick();
    total++; if (!ok) $display("FAIL t6b_timeout: no done_o within budget"); else passed++;
    total++; if (n_done != 1) $display("FAIL t6b_done_count: got %0d want 1", n_done); else passed++;
    total++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 12'h300 || rd_addr[1] !== 12'h301)
      $display("FAIL t6b_latched: got n=%0d want reads 300,301", rd_addr.size());
    else passed++;

    clear_log();
    issue(0, 0, 0, 'h400, 1'b0);
    wait_done(200, ok);
    total++; if (!ok) $display("FAIL t6c_timeout: no done_o within budget"); else passed++;
    total++; if (rd_addr.size() != 1 || rd_addr[0] !== 12'h400) $display("FAIL t6c_second_cmd: got n=%0d want one read at 400", rd_addr.size()); else passed++;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; weights_rdy_i = 1'b0; stall_i = 1'b0;
    n_rows_m1_i = '0; k_tiles_m1_i = '0; n_tiles_m1_i = '0; base_addr_i = '0;
    last_sel = '0;
    clear_log();
    test_reset();
    test_single_tile();
    test_tile_grid();
    test_weights_wait();
    test_stall();
    test_mid_reset();
    test_start_handshake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
